// File: rtl/exe_stage_if.sv
// EXE-stage bus: ID/EX control and operands in, EXE/MEM results and the branch request out.
// The ID/EX side is the master and the execute stage is the slave.
interface exe_stage_if;
  logic        freeze;

  logic        WB_EN_IN;
  logic        MEM_R_EN_IN;
  logic        MEM_W_EN_IN;
  logic        B_IN;
  logic        S_IN;
  logic [3:0]  EXE_CMD;
  logic [31:0] PC;
  logic [31:0] Val_Rn;
  logic [31:0] Val_Rm;
  logic        imm;
  logic [11:0] Shift_operand;
  logic [23:0] Signed_imm_24;
  logic [3:0]  Dest_IN;

  logic        Br_taken;
  logic [31:0] Br_addr;
  logic [3:0]  SR;
  logic        WB_EN;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] ALU_Res;
  logic [31:0] ST_val;
  logic [3:0]  Dest;

  modport master (
    output freeze,
    output WB_EN_IN,
    output MEM_R_EN_IN,
    output MEM_W_EN_IN,
    output B_IN,
    output S_IN,
    output EXE_CMD,
    output PC,
    output Val_Rn,
    output Val_Rm,
    output imm,
    output Shift_operand,
    output Signed_imm_24,
    output Dest_IN,
    input  Br_taken,
    input  Br_addr,
    input  SR,
    input  WB_EN,
    input  MEM_R_EN,
    input  MEM_W_EN,
    input  ALU_Res,
    input  ST_val,
    input  Dest
  );

  modport slave (
    input  freeze,
    input  WB_EN_IN,
    input  MEM_R_EN_IN,
    input  MEM_W_EN_IN,
    input  B_IN,
    input  S_IN,
    input  EXE_CMD,
    input  PC,
    input  Val_Rn,
    input  Val_Rm,
    input  imm,
    input  Shift_operand,
    input  Signed_imm_24,
    input  Dest_IN,
    output Br_taken,
    output Br_addr,
    output SR,
    output WB_EN,
    output MEM_R_EN,
    output MEM_W_EN,
    output ALU_Res,
    output ST_val,
    output Dest
  );
endinterface

// File: rtl/exe_stage.sv
// Execute stage: operand-2 shifter, ALU with NZCV status register, branch target adder and
// the EXE/MEM pipeline register. Synchronous active-low reset; freeze stalls all state.
module exe_stage (
  input logic        clk,
  input logic        rst,
  exe_stage_if.slave bus
);

  typedef enum logic [3:0] {
    CmdMov = 4'b0001,
    CmdAdd = 4'b0010,
    CmdAdc = 4'b0011,
    CmdSub = 4'b0100,
    CmdSbc = 4'b0101,
    CmdAnd = 4'b0110,
    CmdOrr = 4'b0111,
    CmdEor = 4'b1000,
    CmdMvn = 4'b1001
  } exe_cmd_e;

  exe_cmd_e    cmd;
  logic [3:0]  sr_q, sr_d;
  logic [31:0] alu_res_q;
  logic [31:0] st_val_q;
  logic [3:0]  dest_q;
  logic        wb_en_q, mem_r_en_q, mem_w_en_q;

  logic [31:0] val2;
  logic [63:0] imm_dbl;
  logic [63:0] rm_dbl;
  logic [31:0] imm_rot;
  logic [31:0] rm_ror;
  logic [4:0]  rot_amt;
  logic [4:0]  sh_amt;
  logic [1:0]  sh_type;

  logic [31:0] op_b;
  logic        cin;
  logic [32:0] sum;
  logic        arith;
  logic        op_valid;
  logic [31:0] alu_res;
  logic        flag_c, flag_v;

  assign cmd     = exe_cmd_e'(bus.EXE_CMD);
  assign rot_amt = {bus.Shift_operand[11:8], 1'b0};
  assign sh_amt  = bus.Shift_operand[11:7];
  assign sh_type = bus.Shift_operand[6:5];

  // Rotations take the low word of a doubled operand shifted right.
  assign imm_dbl = {24'b0, bus.Shift_operand[7:0], 24'b0, bus.Shift_operand[7:0]} >> rot_amt;
  assign rm_dbl  = {bus.Val_Rm, bus.Val_Rm} >> sh_amt;
  assign imm_rot = imm_dbl[31:0];
  assign rm_ror  = rm_dbl[31:0];

  always_comb begin
    val2 = bus.Val_Rm;
    if (bus.imm) begin
      val2 = imm_rot;
    end else if (bus.MEM_R_EN_IN || bus.MEM_W_EN_IN) begin
      val2 = {20'b0, bus.Shift_operand};
    end else begin
      unique case (sh_type)
        2'b00:   val2 = bus.Val_Rm << sh_amt;
        2'b01:   val2 = bus.Val_Rm >> sh_amt;
        2'b10:   val2 = $unsigned($signed(bus.Val_Rm) >>> sh_amt);
        default: val2 = rm_ror;
      endcase
    end
  end

  // Subtraction runs through the adder as Rn + ~Val2 + carry, so C comes out as NOT borrow.
  always_comb begin
    op_b     = val2;
    cin      = 1'b0;
    arith    = 1'b0;
    op_valid = 1'b1;
    unique case (cmd)
      CmdAdd: arith = 1'b1;
      CmdAdc: begin
        arith = 1'b1;
        cin   = sr_q[1];
      end
      CmdSub: begin
        arith = 1'b1;
        op_b  = ~val2;
        cin   = 1'b1;
      end
      CmdSbc: begin
        arith = 1'b1;
        op_b  = ~val2;
        cin   = sr_q[1];
      end
      CmdMov, CmdMvn, CmdAnd, CmdOrr, CmdEor: ;
      default: op_valid = 1'b0;
    endcase
  end

  assign sum = {1'b0, bus.Val_Rn} + {1'b0, op_b} + {32'b0, cin};

  always_comb begin
    alu_res = 32'b0;
    unique case (cmd)
      CmdMov:                         alu_res = val2;
      CmdMvn:                         alu_res = ~val2;
      CmdAdd, CmdAdc, CmdSub, CmdSbc: alu_res = sum[31:0];
      CmdAnd:                         alu_res = bus.Val_Rn & val2;
      CmdOrr:                         alu_res = bus.Val_Rn | val2;
      CmdEor:                         alu_res = bus.Val_Rn ^ val2;
      default:                        alu_res = 32'b0;
    endcase
  end

  always_comb begin
    flag_c = sr_q[1];
    flag_v = sr_q[0];
    if (arith) begin
      flag_c = sum[32];
      flag_v = (bus.Val_Rn[31] == op_b[31]) && (sum[31] != bus.Val_Rn[31]);
    end
  end

  always_comb begin
    sr_d = sr_q;
    if (bus.S_IN && op_valid) begin
      sr_d = {alu_res[31], alu_res == 32'b0, flag_c, flag_v};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr_q       <= 4'b0;
      alu_res_q  <= 32'b0;
      st_val_q   <= 32'b0;
      dest_q     <= 4'b0;
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
    end else if (!bus.freeze) begin
      sr_q       <= sr_d;
      alu_res_q  <= alu_res;
      st_val_q   <= bus.Val_Rm;
      dest_q     <= bus.Dest_IN;
      wb_en_q    <= bus.WB_EN_IN;
      mem_r_en_q <= bus.MEM_R_EN_IN;
      mem_w_en_q <= bus.MEM_W_EN_IN;
    end
  end

  assign bus.SR       = sr_q;
  assign bus.ALU_Res  = alu_res_q;
  assign bus.ST_val   = st_val_q;
  assign bus.Dest     = dest_q;
  assign bus.WB_EN    = wb_en_q;
  assign bus.MEM_R_EN = mem_r_en_q;
  assign bus.MEM_W_EN = mem_w_en_q;

  assign bus.Br_taken = bus.B_IN;
  assign bus.Br_addr  = bus.PC + {{6{bus.Signed_imm_24[23]}}, bus.Signed_imm_24, 2'b00};

endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 SHALL have port clk, input, 1: single rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1: reset, synchronous, active-low (sampled only on rising clk; rst=0 resets).
REQ-003 SHALL have port freeze, input, 1: memory stall; holds all registered state.
REQ-004 SHALL have ports WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN, input, 1 each: control bits from the ID/EX register.
REQ-005 SHALL have port EXE_CMD, input, 4: ALU opcode.
REQ-006 SHALL have ports PC, Val_Rn, Val_Rm, input, 32 each: PC+4 of the instruction and the two operands.
REQ-007 SHALL have ports imm (input, 1), Shift_operand (input, 12), Signed_imm_24 (input, 24), Dest_IN (input, 4).
REQ-008 SHALL have ports Br_taken (output, 1) and Br_addr (output, 32): combinational branch request to fetch.
REQ-009 SHALL have port SR, output, 4: registered status {N,Z,C,V}; fed back to ID for condition check.
REQ-010 SHALL have ports WB_EN, MEM_R_EN, MEM_W_EN (output, 1 each), ALU_Res (output, 32), ST_val (output, 32), Dest (output, 4): registered EXE/MEM outputs.

Function
REQ-011 SHALL compute Val2 combinationally. imm=1: zero-extended Shift_operand[7:0] rotated right by 2*Shift_operand[11:8].
REQ-012 Val2 with imm=0 and (MEM_R_EN_IN or MEM_W_EN_IN): zero-extended Shift_operand[11:0].
REQ-013 Val2 otherwise: Val_Rm shifted by Shift_operand[11:7] using type Shift_operand[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR); amount 0 passes Val_Rm unchanged.
REQ-014 SHALL decode EXE_CMD: 0001 MOV=Val2; 1001 MVN=~Val2; 0010 ADD=Rn+Val2; 0011 ADC=Rn+Val2+C; 0100 SUB=Rn-Val2; 0101 SBC=Rn-Val2-!C; 0110 AND; 0111 ORR; 1000 EOR; any other code gives result 0 and leaves flags unchanged.
REQ-015 SHALL use C from the registered SR as carry-in.
REQ-016 SHALL form flags as N=res[31] and Z=(res==0) for every op.
REQ-017 Arithmetic ops: C=bit 32 of the 33-bit sum; for SUB/SBC, C=NOT borrow.
REQ-018 Arithmetic ops: V=signed overflow of the 32-bit operation.
REQ-019 Logical/move ops SHALL keep the prior C and V.
REQ-020 SHALL load SR with the new flags on a clk edge only when S_IN=1, freeze=0 and rst=1.
REQ-021 SHALL drive Br_taken=B_IN and Br_addr=PC+(sign-extended Signed_imm_24 << 2) combinationally (32-bit wrap), regardless of freeze.
REQ-022 SHALL load ALU_Res, ST_val<=Val_Rm, Dest<=Dest_IN and the three enables on each clk edge with freeze=0; latency 1 cycle.
REQ-023 freeze=1 SHALL hold every registered output and SR unchanged.
REQ-024 Simultaneous rst=0 and freeze=1: reset SHALL win.

Reset
REQ-025 On a clk edge with rst=0: SR, ALU_Res, ST_val, Dest, WB_EN, MEM_R_EN and MEM_W_EN SHALL all be 0.
REQ-026 Reset asserted mid-stream SHALL discard the in-flight instruction; the first edge with rst=1 loads the current inputs normally.
REQ-027 Br_taken and Br_addr are combinational and SHALL not be affected by rst.

Verification
REQ-028 ADD with S=1, Rn=0x7FFFFFFF, imm=1, Shift_operand=0x001 -> ALU_Res=0x80000000, SR=1001 (N,V) after 1 edge.
REQ-029 SUB with S=1, Rn=5, Val2=5 -> ALU_Res=0, SR=0110 (Z,C); same op with S=0 -> SR unchanged.
REQ-030 MOV, imm=0, Val_Rm=0x80000001, Shift_operand[11:7]=1, type ROR -> ALU_Res=0xC0000000.
REQ-031 B_IN=1, PC=0x100, Signed_imm_24=0xFFFFFE -> Br_taken=1, Br_addr=0xF8 in the same cycle.
REQ-032 freeze=1 held 3 cycles with changing inputs -> outputs and SR constant; rst=0 during freeze -> all registered outputs 0 next edge.
REQ-033 ADC with C=1, Rn=0xFFFFFFFF, Val2=0 -> ALU_Res=0, C=1, Z=1.
